// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard controller bundle: hazard inputs from the datapath and the
// stall/bubble/divide/perf controls back to it.
interface hazard_ctrl_if;
    logic [4:0]  ID_REG_READ_ADDR1;
    logic [4:0]  ID_REG_READ_ADDR2;
    logic        ID_USES_RS1;
    logic        ID_USES_RS2;
    logic [4:0]  EX_REG_WRITE_ADDR;
    logic [3:0]  EX_DATA_MEM_READ;
    logic        EX_BRANCH_TAKEN;
    logic        EX_MULDIV_MULTI;
    logic        MULDIV_DONE;
    logic        DMEM_BUSY;

    logic        PC_STALL;
    logic        IF_ID_STALL;
    logic        ID_EX_STALL;
    logic        EX_MEM_STALL;
    logic        IF_ID_FLUSH;
    logic        ID_EX_BUBBLE;
    logic        EX_MEM_BUBBLE;
    logic        MEM_WB_BUBBLE;
    logic        MULDIV_START;
    logic        MULDIV_ABORT;
    logic        DIV_ERR;
    logic [31:0] PERF_STALL_CYCLES;
    logic [31:0] PERF_FLUSHES;

    // Controller side
    modport master (
        input  ID_REG_READ_ADDR1, ID_REG_READ_ADDR2, ID_USES_RS1, ID_USES_RS2,
               EX_REG_WRITE_ADDR, EX_DATA_MEM_READ, EX_BRANCH_TAKEN,
               EX_MULDIV_MULTI, MULDIV_DONE, DMEM_BUSY,
        output PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL,
               IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_BUBBLE, MEM_WB_BUBBLE,
               MULDIV_START, MULDIV_ABORT, DIV_ERR,
               PERF_STALL_CYCLES, PERF_FLUSHES
    );

    // Datapath side
    modport slave (
        output ID_REG_READ_ADDR1, ID_REG_READ_ADDR2, ID_USES_RS1, ID_USES_RS2,
               EX_REG_WRITE_ADDR, EX_DATA_MEM_READ, EX_BRANCH_TAKEN,
               EX_MULDIV_MULTI, MULDIV_DONE, DMEM_BUSY,
        input  PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL,
               IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_BUBBLE, MEM_WB_BUBBLE,
               MULDIV_START, MULDIV_ABORT, DIV_ERR,
               PERF_STALL_CYCLES, PERF_FLUSHES
    );
endinterface

// File: rtl/hazard_ctrl.sv
// RV32IM 5-stage hazard/stall controller with divide start/done sequencing and watchdog.
// Optional perf counters built only when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic          CLK,
    input  logic          RESET_N,
    hazard_ctrl_if.master hz
);

    typedef enum logic {RUN, DIV_WAIT} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       done_pending, done_pending_nxt;
    logic       div_err;

    logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble;
    logic muldiv_start, muldiv_abort;

    logic rs1_hit, rs2_hit, load_use;

    // x0 never forms a hazard, so rd==0 blocks the match
    assign rs1_hit  = hz.ID_USES_RS1 && (hz.ID_REG_READ_ADDR1 == hz.EX_REG_WRITE_ADDR);
    assign rs2_hit  = hz.ID_USES_RS2 && (hz.ID_REG_READ_ADDR2 == hz.EX_REG_WRITE_ADDR);
    assign load_use = (|hz.EX_DATA_MEM_READ) && (|hz.EX_REG_WRITE_ADDR) && (rs1_hit || rs2_hit);

    always_comb begin
        state_nxt        = state;
        wait_cnt_nxt     = wait_cnt;
        done_pending_nxt = done_pending;
        pc_stall         = 1'b0;
        if_id_stall      = 1'b0;
        id_ex_stall      = 1'b0;
        ex_mem_stall     = 1'b0;
        if_id_flush      = 1'b0;
        id_ex_bubble     = 1'b0;
        ex_mem_bubble    = 1'b0;
        mem_wb_bubble    = 1'b0;
        muldiv_start     = 1'b0;
        muldiv_abort     = 1'b0;

        if (hz.DMEM_BUSY) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
            // Only a DONE that belongs to an outstanding divide is remembered
            if (hz.MULDIV_DONE && (state == DIV_WAIT))
                done_pending_nxt = 1'b1;
        end else if (state == RUN && hz.EX_MULDIV_MULTI) begin
            muldiv_start  = 1'b1;
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
            state_nxt     = DIV_WAIT;
            wait_cnt_nxt  = 8'd0;
        end else if (state == DIV_WAIT) begin
            if (hz.MULDIV_DONE || done_pending) begin
                // Release so EX/MEM captures the divide result this edge
                done_pending_nxt = 1'b0;
                state_nxt        = RUN;
            end else if (wait_cnt == WAIT_LAST) begin
                muldiv_abort = 1'b1;
                state_nxt    = RUN;
            end else begin
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_ex_stall   = 1'b1;
                ex_mem_bubble = 1'b1;
                wait_cnt_nxt  = wait_cnt + 8'd1;
            end
        end else if (hz.EX_BRANCH_TAKEN) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= RUN;
            wait_cnt     <= 8'd0;
            done_pending <= 1'b0;
            div_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_cnt_nxt;
            done_pending <= done_pending_nxt;
            div_err      <= div_err | muldiv_abort;
        end
    end

    // Reset forces every control low even while inputs are still active
    assign hz.PC_STALL      = RESET_N & pc_stall;
    assign hz.IF_ID_STALL   = RESET_N & if_id_stall;
    assign hz.ID_EX_STALL   = RESET_N & id_ex_stall;
    assign hz.EX_MEM_STALL  = RESET_N & ex_mem_stall;
    assign hz.IF_ID_FLUSH   = RESET_N & if_id_flush;
    assign hz.ID_EX_BUBBLE  = RESET_N & id_ex_bubble;
    assign hz.EX_MEM_BUBBLE = RESET_N & ex_mem_bubble;
    assign hz.MEM_WB_BUBBLE = RESET_N & mem_wb_bubble;
    assign hz.MULDIV_START  = RESET_N & muldiv_start;
    assign hz.MULDIV_ABORT  = RESET_N & muldiv_abort;
    assign hz.DIV_ERR       = RESET_N & div_err;

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flushes;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            perf_stall_cycles <= 32'd0;
            perf_flushes      <= 32'd0;
        end else begin
            if (pc_stall)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (if_id_flush)
                perf_flushes <= perf_flushes + 32'd1;
        end
    end

    assign hz.PERF_STALL_CYCLES = perf_stall_cycles;
    assign hz.PERF_FLUSHES      = perf_flushes;
`else
    assign hz.PERF_STALL_CYCLES = 32'd0;
    assign hz.PERF_FLUSHES      = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (TIMEOUT_CYCLES=8): load-use, branch, divide,
// freeze-during-done, watchdog timeout and reset mid-divide.
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    // Output vector bit order:
    // [10]PC_STALL [9]IF_ID_STALL [8]ID_EX_STALL [7]EX_MEM_STALL [6]IF_ID_FLUSH
    // [5]ID_EX_BUBBLE [4]EX_MEM_BUBBLE [3]MEM_WB_BUBBLE [2]START [1]ABORT [0]DIV_ERR
    localparam logic [10:0] O_NONE   = 11'b00000000000;
    localparam logic [10:0] O_LU     = 11'b11000100000;
    localparam logic [10:0] O_BR     = 11'b00001100000;
    localparam logic [10:0] O_DSTART = 11'b11100010100;
    localparam logic [10:0] O_DWAIT  = 11'b11100010000;
    localparam logic [10:0] O_FREEZE = 11'b11110001000;
    localparam logic [10:0] O_ABORT  = 11'b00000000010;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   exp_stalls;
    int   exp_flushes;
    logic exp_err;

    hazard_ctrl_if hif ();

    hazard_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .hz      (hif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic [3:0] mr,
                         input logic br, input logic mul, input logic dn, input logic bsy);
        hif.ID_REG_READ_ADDR1 = rs1;
        hif.ID_USES_RS1       = u1;
        hif.ID_REG_READ_ADDR2 = rs2;
        hif.ID_USES_RS2       = u2;
        hif.EX_REG_WRITE_ADDR = rd;
        hif.EX_DATA_MEM_READ  = mr;
        hif.EX_BRANCH_TAKEN   = br;
        hif.EX_MULDIV_MULTI   = mul;
        hif.MULDIV_DONE       = dn;
        hif.DMEM_BUSY         = bsy;
    endtask

    task automatic check_outs(input string tag, input logic [10:0] e);
        logic [10:0] want;
        logic [10:0] got;
        want = e | {10'd0, exp_err};
        got  = {hif.PC_STALL, hif.IF_ID_STALL, hif.ID_EX_STALL, hif.EX_MEM_STALL,
                hif.IF_ID_FLUSH, hif.ID_EX_BUBBLE, hif.EX_MEM_BUBBLE, hif.MEM_WB_BUBBLE,
                hif.MULDIV_START, hif.MULDIV_ABORT, hif.DIV_ERR};
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: outputs got %b want %b", tag, got, want);
        end
    endtask

    // One pipeline cycle: drive at negedge, sample 1 time unit later
    task automatic cyc(input string tag, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic [3:0] mr, input logic br, input logic mul,
                       input logic dn, input logic bsy, input logic [10:0] e);
        @(negedge clk);
        drive(rs1, u1, rs2, u2, rd, mr, br, mul, dn, bsy);
        #1;
        check_outs(tag, e);
        if (e[10]) exp_stalls++;
        if (e[6])  exp_flushes++;
        if (e[1])  exp_err = 1'b1;
    endtask

    task automatic check_perf(input string tag);
        logic [31:0] want_s;
        logic [31:0] want_f;
        @(posedge clk);
        #1;
        want_s = PERF_ON ? 32'(exp_stalls) : 32'd0;
        want_f = PERF_ON ? 32'(exp_flushes) : 32'd0;
        n_cmp++;
        assert (hif.PERF_STALL_CYCLES === want_s) else begin
            n_bad++;
            $error("FAIL %s_stall_cycles: got %0d want %0d", tag, hif.PERF_STALL_CYCLES, want_s);
        end
        n_cmp++;
        assert (hif.PERF_FLUSHES === want_f) else begin
            n_bad++;
            $error("FAIL %s_flushes: got %0d want %0d", tag, hif.PERF_FLUSHES, want_f);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        exp_stalls  = 0;
        exp_flushes = 0;
        exp_err     = 1'b0;
        rst_n       = 1'b1;
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;

        // Reset with busy/divide/load-use inputs active: everything low
        @(negedge clk);
        drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        check_outs("reset_outs", O_NONE);
        check_perf("reset_perf");
        release_reset();

        // Load-use and its non-hazard variants
        cyc("idle",        5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        cyc("lu_rs1",      5'd5, 1'b1, 5'd7, 1'b1, 5'd5, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, O_LU);
        cyc("lu_bubble",   5'd5, 1'b1, 5'd7, 1'b1, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        cyc("lu_rd_x0",    5'd0, 1'b1, 5'd7, 1'b1, 5'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        cyc("lu_no_use",   5'd5, 1'b0, 5'd7, 1'b1, 5'd5, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        cyc("lu_not_load", 5'd5, 1'b1, 5'd7, 1'b1, 5'd5, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        cyc("lu_rs2",      5'd1, 1'b1, 5'd9, 1'b1, 5'd9, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, O_LU);
        cyc("branch_lu",   5'd5, 1'b1, 5'd7, 1'b1, 5'd5, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, O_BR);
        cyc("freeze_run",  5'd5, 1'b1, 5'd7, 1'b1, 5'd5, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, O_FREEZE);
        check_perf("after_lu");

        // Divide: START, 5 wait cycles, DONE releases (6 stall cycles)
        cyc("div_start",   5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_DSTART);
        for (int i = 0; i < 5; i++)
            cyc("div_wait", 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_DWAIT);
        cyc("div_done",    5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_NONE);
        cyc("div_after",   5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        check_perf("after_div");

        // DONE lands in a 2-cycle freeze; release comes from done_pending
        cyc("fz_start",    5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_DSTART);
        cyc("fz_wait0",    5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_DWAIT);
        cyc("fz_wait1",    5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_DWAIT);
        cyc("fz_done",     5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, O_FREEZE);
        cyc("fz_hold",     5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, O_FREEZE);
        cyc("fz_release",  5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_NONE);
        cyc("fz_run",      5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, O_LU);
        check_perf("after_freeze");

        // Watchdog: no DONE, ABORT on the 8th DIV_WAIT cycle
        cyc("to_start",    5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_DSTART);
        for (int i = 0; i < 7; i++)
            cyc("to_wait", 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_DWAIT);
        cyc("to_abort",    5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_ABORT);
        cyc("to_err",      5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        cyc("to_err_br",   5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_BR);
        check_perf("after_timeout");

        // Reset while DIV_WAIT with counter=3
        cyc("rd_start",    5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_DSTART);
        for (int i = 0; i < 3; i++)
            cyc("rd_wait", 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_DWAIT);
        @(negedge clk);
        rst_n       = 1'b0;
        exp_err     = 1'b0;
        exp_stalls  = 0;
        exp_flushes = 0;
        #1;
        check_outs("rd_reset_outs", O_NONE);
        check_perf("rd_reset_perf");
        release_reset();
        cyc("rd_run",      5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        cyc("rd_restart",  5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_DSTART);
        cyc("rd_wait2",    5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_DWAIT);
        cyc("rd_done",     5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_NONE);
        cyc("rd_idle",     5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        check_perf("after_reset_div");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
